x3q_fetch_unit: RTL and testbench
=================================

// Module: x3q_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation x3q core.
//  Replaces the core's serial fetch/setup stages with a prefetch queue.
//  Issues sequential single-word reads on the memory request bus and buffers
//  up to DEPTH {address, instruction} pairs for the execute stage.
//  Supports taken-jump redirect with flush, and drops stale in-flight responses.
// PARAMETERS
//  ADDR_W      16  request/program-counter width
//  INSTR_W     16  instruction word width
//  DEPTH       4   prefetch queue entries; power of 2, >= 2
//  INC         1   PC increment per fetched word
//  RESET_ADDR  0   fetch PC after reset
// PORTS
//  clk               in   1        clock; all logic on rising edge
//  reset             in   1        asynchronous, active-low reset
//  fetch_enable      in   1        1 = new requests may be issued
//  request           out  1        one-cycle read request pulse
//  request_address   out  ADDR_W   address of the current/last request
//  memory_in         in   INSTR_W  read data; valid while memory_ready=1
//  memory_ready      in   1        one-cycle read-complete strobe
//  instr_valid       out  1        queue head valid (count != 0)
//  instr_data        out  INSTR_W  head instruction
//  instr_address     out  ADDR_W   address of head instruction
//  instr_take        in   1        pop head; ignored when instr_valid=0
//  redirect          in   1        flush queue, restart fetch at redirect_address
//  redirect_address  in   ADDR_W   new fetch PC
//  occupancy         out  clog2(DEPTH+1)  entries held
// BEHAVIOUR
//  Reset (reset=0): request=0, request_address=0, fetch_pc=RESET_ADDR, count=0,
//   rd/wr pointers=0, state=IDLE; instr_valid=0, occupancy=0, head outputs=0.
//   An in-flight read is abandoned; a memory_ready after reset is ignored.
//  States: IDLE (nothing outstanding), WAIT (one read outstanding),
//   DISCARD (one read outstanding whose data must be dropped).
//  IDLE: if fetch_enable && !redirect && count<DEPTH: request<=1,
//   request_address<=fetch_pc, -> WAIT. memory_ready is ignored in IDLE.
//  WAIT: on memory_ready, push {fetch_pc, memory_in};
//   fetch_pc <= fetch_pc+INC, modulo 2^ADDR_W; -> IDLE. fetch_enable=0
//   does not cancel an outstanding read.
//  DISCARD: on memory_ready, drop data, -> IDLE.
//  At most one read outstanding; max issue rate 1 request per 2 cycles.
//  Push always has room: a request is issued only if count<DEPTH, and a pop
//   cannot underflow.
//  request is high for exactly one cycle per issue; request_address holds.
//  Pop: instr_take && instr_valid advances rd pointer. Push and pop in the
//   same cycle leave count unchanged.
//  Outputs instr_valid/instr_data/instr_address/occupancy come from registers
//   only; no combinational path from inputs.
//  Redirect, which has priority over push, pop and issue:
//   - next cycle: count=0 and pointers reset; fetch_pc=redirect_address.
//   - in WAIT without memory_ready -> DISCARD.
//   - in WAIT with memory_ready in the same cycle: data dropped, -> IDLE.
//   - in DISCARD: update fetch_pc, stay in DISCARD.
//   - in IDLE: no request this cycle; fetch restarts in the next cycle.
//  Queue index wrap: pointers are clog2(DEPTH) bits and wrap naturally.
// TESTING
//  1 DEPTH=4, RESET_ADDR=0, memory answers 2 cycles after request with
//    data=addr^16'hA5A5, no take -> four requests to 0..3, then request stays
//    0; occupancy=4; head=(0000,A5A5).
//  2 As 1 with instr_take held high -> instr_address sequence 0,1,2,3,...;
//    data matches; occupancy never exceeds 1.
//  3 redirect to 16'h0040 while WAIT for addr 5 -> addr-5 response dropped;
//    occupancy=0 next cycle; next request address 0x0040; first head 0x0040.
//  4 redirect in the same cycle as memory_ready -> nothing pushed; state
//    IDLE; next request address = redirect_address.
//  5 RESET_ADDR=16'hFFFE -> instr_address FFFE, FFFF, 0000 (wrap).
//  6 fetch_enable=0 from reset -> request never asserts. Then assert reset
//    while WAIT -> all outputs 0; late memory_ready is ignored; fetch restarts
//    at RESET_ADDR.

Source files
------------

// File: rtl/x3q_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : x3q_fetch_unit
// Description : Instruction-fetch front end with a prefetch queue. Issues
//               sequential single-word reads on the memory request bus and
//               buffers up to DEPTH {address, instruction} pairs for the
//               execute stage. A taken-jump redirect flushes the queue and
//               restarts fetch; a read still in flight at the redirect is
//               dropped when it completes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               in   clock, rising edge
//   reset             in   asynchronous active-low reset
//   fetch_enable      in   1 = new requests may be issued
//   request           out  one-cycle read request pulse
//   request_address   out  address of the current/last request (holds)
//   memory_in         in   read data, valid while memory_ready=1
//   memory_ready      in   one-cycle read-complete strobe
//   instr_valid       out  queue head valid
//   instr_data        out  head instruction
//   instr_address     out  address of head instruction
//   instr_take        in   pop head (ignored when instr_valid=0)
//   redirect          in   flush queue, restart fetch at redirect_address
//   redirect_address  in   new fetch PC
//   occupancy         out  number of queued entries
// ============================================================================
module x3q_fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter int                DEPTH      = 4,
  parameter int                INC        = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fetch_enable,
  output logic                         request,
  output logic [ADDR_W-1:0]            request_address,
  input  logic [INSTR_W-1:0]           memory_in,
  input  logic                         memory_ready,
  output logic                         instr_valid,
  output logic [INSTR_W-1:0]           instr_data,
  output logic [ADDR_W-1:0]            instr_address,
  input  logic                         instr_take,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_address,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);

  // Fetch sequencer states
  localparam logic [1:0] c_IDLE    = 2'd0;  // nothing outstanding
  localparam logic [1:0] c_WAIT    = 2'd1;  // one read outstanding
  localparam logic [1:0] c_DISCARD = 2'd2;  // one read outstanding, data stale

  logic [1:0]          r_state;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic                r_req;
  logic [ADDR_W-1:0]   r_req_addr;

  logic [INSTR_W-1:0]  r_q_data [DEPTH];
  logic [ADDR_W-1:0]   r_q_addr [DEPTH];
  logic [c_PTR_W-1:0]  r_rd;
  logic [c_PTR_W-1:0]  r_wr;
  logic [c_CNT_W-1:0]  r_count;

  logic w_has_room;
  logic w_issue;
  logic w_push;
  logic w_pop;

  // Redirect overrides every other queue/fetch action in the same cycle.
  // Issue is gated on free space, so a later push can never overflow: at
  // most one read is outstanding and it was issued only while count<DEPTH.
  assign w_has_room = (r_count < c_CNT_W'(DEPTH));
  assign w_issue    = (r_state == c_IDLE) && fetch_enable && !redirect && w_has_room;
  assign w_push     = (r_state == c_WAIT) && memory_ready && !redirect;
  assign w_pop      = instr_take && (r_count != '0) && !redirect;

  // --------------------------------------------------------------------------
  // Fetch sequencer, PC and request bus
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_fetch_pc <= RESET_ADDR;
      r_req      <= 1'b0;
      r_req_addr <= '0;
    end else begin
      r_req <= w_issue;
      if (w_issue) begin
        r_req_addr <= r_fetch_pc;
      end

      if (redirect) begin
        r_fetch_pc <= redirect_address;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(INC);
      end

      case (r_state)
        c_IDLE: begin
          if (w_issue) begin
            r_state <= c_WAIT;
          end
        end
        c_WAIT: begin
          // A completion in the redirect cycle is simply not pushed, so the
          // read is finished and the sequencer can return to IDLE.
          if (memory_ready) begin
            r_state <= c_IDLE;
          end else if (redirect) begin
            r_state <= c_DISCARD;
          end
        end
        c_DISCARD: begin
          // Further redirects only move the PC; the stale read still has to
          // be absorbed before a new one may be issued.
          if (memory_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Prefetch queue: pointers are c_PTR_W bits wide and wrap on their own
  // because DEPTH is a power of two.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is reset so that the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_addr[i] <= '0;
      end
    end else if (w_push) begin
      r_q_data[r_wr] <= memory_in;
      r_q_addr[r_wr] <= r_fetch_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all driven from registers, no combinational input path
  // --------------------------------------------------------------------------
  assign request         = r_req;
  assign request_address = r_req_addr;
  assign instr_valid     = (r_count != '0);
  assign instr_data      = r_q_data[r_rd];
  assign instr_address   = r_q_addr[r_rd];
  assign occupancy       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_x3q_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_x3q_fetch_unit
// Description : Scoreboard bench for x3q_fetch_unit. Directed phases push
//               expected request addresses and {address, data} queue entries;
//               independent monitors pop and compare whenever the DUT shows a
//               request or a taken head entry. A second instance checks PC
//               wrap from a non-zero reset address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x3q_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: RESET_ADDR = 0 ----------------
  logic        reset = 1'b0;
  logic        fetch_enable = 1'b0;
  logic        request;
  logic [15:0] request_address;
  logic [15:0] memory_in;
  logic        memory_ready;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_address;
  logic        instr_take = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_address = 16'h0000;
  logic [2:0]  occupancy;

  x3q_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .INC(1), .RESET_ADDR(16'h0000)) dut (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
    .request(request), .request_address(request_address),
    .memory_in(memory_in), .memory_ready(memory_ready),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_address(instr_address),
    .instr_take(instr_take), .redirect(redirect), .redirect_address(redirect_address),
    .occupancy(occupancy)
  );

  // ---------------- instance B: RESET_ADDR = FFFE ----------------
  logic        reset_b = 1'b0;
  logic        fetch_enable_b = 1'b0;
  logic        request_b;
  logic [15:0] request_address_b;
  logic [15:0] memory_in_b;
  logic        memory_ready_b;
  logic        instr_valid_b;
  logic [15:0] instr_data_b;
  logic [15:0] instr_address_b;
  logic        instr_take_b = 1'b0;
  logic        redirect_b = 1'b0;
  logic [15:0] redirect_address_b = 16'h0000;
  logic [2:0]  occupancy_b;

  x3q_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .INC(1), .RESET_ADDR(16'hFFFE)) dut_b (
    .clk(clk), .reset(reset_b), .fetch_enable(fetch_enable_b),
    .request(request_b), .request_address(request_address_b),
    .memory_in(memory_in_b), .memory_ready(memory_ready_b),
    .instr_valid(instr_valid_b), .instr_data(instr_data_b), .instr_address(instr_address_b),
    .instr_take(instr_take_b), .redirect(redirect_b), .redirect_address(redirect_address_b),
    .occupancy(occupancy_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [15:0] exp_req[$];
  logic [31:0] exp_instr[$];
  logic [31:0] exp_b[$];
  bit          track_occ = 1'b0;
  int          max_occ = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [31:0] ent(input logic [15:0] a);
    return {a, a ^ 16'hA5A5};
  endfunction

  // ---------------- memory models: answer with addr^A5A5 ----------------
  initial begin : mem_a
    int          pend;
    logic [15:0] pa;
    pend = 0; pa = '0;
    memory_ready = 1'b0; memory_in = '0;
    forever begin
      @(negedge clk);
      memory_ready = 1'b0;
      if (pend == 1) begin
        memory_ready = 1'b1;
        memory_in = pa ^ 16'hA5A5;
        pend = 0;
      end else if (pend > 1) pend--;
      if (request) begin
        pa = request_address;
        pend = 2;
      end
    end
  end

  initial begin : mem_b
    int          pend;
    logic [15:0] pa;
    pend = 0; pa = '0;
    memory_ready_b = 1'b0; memory_in_b = '0;
    forever begin
      @(negedge clk);
      memory_ready_b = 1'b0;
      if (pend == 1) begin
        memory_ready_b = 1'b1;
        memory_in_b = pa ^ 16'hA5A5;
        pend = 0;
      end else if (pend > 1) pend--;
      if (request_b) begin
        pa = request_address_b;
        pend = 2;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin : mon_req
    logic [15:0] e;
    forever begin
      @(negedge clk); #2;
      if (request) begin
        if (exp_req.size() == 0) begin
          checks++;
          $display("FAIL unexpected_request: got request to %h, required no request", request_address);
        end else begin
          e = exp_req.pop_front();
          chk("request_address", {16'h0, request_address}, {16'h0, e});
        end
      end
    end
  end

  initial begin : mon_instr
    logic [31:0] e;
    forever begin
      @(negedge clk); #2;
      if (track_occ && int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (instr_valid && instr_take) begin
        if (exp_instr.size() == 0) begin
          checks++;
          $display("FAIL unexpected_instr: got %h/%h, required nothing", instr_address, instr_data);
        end else begin
          e = exp_instr.pop_front();
          chk("head_entry", {instr_address, instr_data}, e);
        end
      end
    end
  end

  initial begin : mon_b
    logic [31:0] e;
    forever begin
      @(negedge clk); #2;
      if (instr_valid_b && instr_take_b && exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("wrap_head_entry", {instr_address_b, instr_data_b}, e);
      end
    end
  end

  task automatic wait_req(input logic [15:0] a, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(request && request_address == a) && n < budget);
    if (!(request && request_address == a)) begin
      checks++;
      $display("FAIL wait_request: no request to %h within %0d cycles", a, budget);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_request", {31'h0, request}, 32'h0);
    chk("rst_request_address", {16'h0, request_address}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_occupancy", {29'h0, occupancy}, 32'h0);
    chk("rst_head", {instr_address, instr_data}, 32'h0);

    // fetch_enable low: no request may ever appear (exp_req is empty)
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_occupancy", {29'h0, occupancy}, 32'h0);

    // Fill: four requests 0..3, then stall with a full queue
    for (int a = 0; a < 4; a++) exp_req.push_back(16'(a));
    fetch_enable = 1'b1;
    repeat (30) @(negedge clk);
    chk("full_occupancy", {29'h0, occupancy}, 32'h4);
    chk("full_valid", {31'h0, instr_valid}, 32'h1);
    chk("full_head", {instr_address, instr_data}, ent(16'h0000));
    chk("fill_requests_seen", exp_req.size(), 0);

    // Drain and stream with take held; redirect while waiting on address 5
    for (int a = 0; a < 5; a++) exp_instr.push_back(ent(16'(a)));
    exp_req.push_back(16'h0004);
    exp_req.push_back(16'h0005);
    instr_take = 1'b1;
    wait_req(16'h0005, 40);
    redirect = 1'b1;
    redirect_address = 16'h0040;
    for (int a = 'h40; a < 'h48; a++) exp_req.push_back(16'(a));
    for (int a = 'h40; a < 'h47; a++) exp_instr.push_back(ent(16'(a)));
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("redirect_occupancy", {29'h0, occupancy}, 32'h0);
    chk("redirect_valid", {31'h0, instr_valid}, 32'h0);
    max_occ = 0;
    track_occ = 1'b1;
    wait_req(16'h0047, 80);
    track_occ = 1'b0;
    chk("stream_max_occupancy", max_occ, 1);
    chk("stream_entries_seen", exp_instr.size(), 0);

    // Asynchronous reset while a read is outstanding
    reset = 1'b0;
    fetch_enable = 1'b0;
    #1;
    chk("async_rst_request", {31'h0, request}, 32'h0);
    chk("async_rst_request_address", {16'h0, request_address}, 32'h0);
    chk("async_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("async_rst_occupancy", {29'h0, occupancy}, 32'h0);
    chk("async_rst_head", {instr_address, instr_data}, 32'h0);
    exp_req.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("late_ready_occupancy", {29'h0, occupancy}, 32'h0);
    chk("late_ready_valid", {31'h0, instr_valid}, 32'h0);

    // Fetch restarts at RESET_ADDR
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0001);
    exp_instr.push_back(ent(16'h0000));
    exp_instr.push_back(ent(16'h0001));
    fetch_enable = 1'b1;
    wait_req(16'h0001, 40);
    fetch_enable = 1'b0;
    repeat (8) @(negedge clk);
    chk("restart_requests_seen", exp_req.size(), 0);
    chk("restart_entries_seen", exp_instr.size(), 0);

    // Redirect coinciding with memory_ready: data dropped, fetch resumes next cycle
    exp_req.push_back(16'h0002);
    fetch_enable = 1'b1;
    wait_req(16'h0002, 10);
    fetch_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1;
    redirect_address = 16'h0100;
    exp_req.push_back(16'h0100);
    exp_instr.push_back(ent(16'h0100));
    @(negedge clk);
    redirect = 1'b0;
    fetch_enable = 1'b1;
    #1;
    chk("same_cycle_occupancy", {29'h0, occupancy}, 32'h0);
    @(negedge clk);
    chk("same_cycle_next_request", {31'h0, request}, 32'h1);
    chk("same_cycle_next_address", {16'h0, request_address}, 32'h0100);
    fetch_enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("same_cycle_requests_seen", exp_req.size(), 0);
    chk("same_cycle_entries_seen", exp_instr.size(), 0);

    // PC wrap from RESET_ADDR = FFFE
    exp_b.push_back(ent(16'hFFFE));
    exp_b.push_back(ent(16'hFFFF));
    exp_b.push_back(ent(16'h0000));
    reset_b = 1'b1;
    fetch_enable_b = 1'b1;
    instr_take_b = 1'b1;
    for (int n = 0; n < 40 && exp_b.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("wrap_entries_seen", exp_b.size(), 0);
    fetch_enable_b = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
